saturating_counter_table: RTL and testbench

SATURATING_COUNTER_TABLE -- requirements
Module: saturating_counter_table

---
 rtl/saturating_counter_table_pkg.sv | 29 ++
 rtl/hysteresis_counter_step.sv | 35 +++
 rtl/saturating_counter_table.sv | 124 ++++++++++++
 tb/tb_saturating_counter_table.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/saturating_counter_table_pkg.sv
// Shared definitions for the saturating counter table: FSM encoding and the
// hysteresis thresholds/jump targets, expressed only in terms of RANGE and COERCIVITY.
package saturating_counter_table_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } sct_state_e;

  // Highest "not taken" state.
  function automatic int counter_half_low(input int range);
    return range / 2 - 1;
  endfunction

  // Lowest "taken" state.
  function automatic int counter_half_high(input int range);
    return range / 2;
  endfunction

  // Crossing into "taken" lands COERCIVITY states past the midpoint.
  function automatic int jump_up_target(input int range, input int coercivity);
    return range / 2 + coercivity;
  endfunction

  function automatic int jump_down_target(input int range, input int coercivity);
    return range / 2 - 1 - coercivity;
  endfunction

endpackage

// File: rtl/hysteresis_counter_step.sv
// Next-value arithmetic for one hysteresis saturating counter. With neither
// (or both) of increment/decrement asserted the count passes through unchanged.
module hysteresis_counter_step
  import saturating_counter_table_pkg::*;
#(
  parameter int RANGE      = 4,
  parameter int RANGE_LOG2 = $clog2(RANGE),
  parameter int COERCIVITY = 1
) (
  input  logic [RANGE_LOG2-1:0] count,
  input  logic                  increment,
  input  logic                  decrement,
  output logic [RANGE_LOG2-1:0] next_count
);

  localparam logic [RANGE_LOG2-1:0] MAX_COUNT = RANGE_LOG2'(RANGE - 1);
  localparam logic [RANGE_LOG2-1:0] HALF_LOW  = RANGE_LOG2'(counter_half_low(RANGE));
  localparam logic [RANGE_LOG2-1:0] HALF_HIGH = RANGE_LOG2'(counter_half_high(RANGE));
  localparam logic [RANGE_LOG2-1:0] JUMP_UP   = RANGE_LOG2'(jump_up_target(RANGE, COERCIVITY));
  localparam logic [RANGE_LOG2-1:0] JUMP_DOWN = RANGE_LOG2'(jump_down_target(RANGE, COERCIVITY));

  always_comb begin
    next_count = count;
    if (increment && !decrement) begin
      if (count == MAX_COUNT)     next_count = count;
      else if (count == HALF_LOW) next_count = JUMP_UP;
      else                        next_count = count + 1'b1;
    end else if (decrement && !increment) begin
      if (count == '0)             next_count = count;
      else if (count == HALF_HIGH) next_count = JUMP_DOWN;
      else                         next_count = count - 1'b1;
    end
  end

endmodule

// File: rtl/saturating_counter_table.sv
// Table of hysteresis saturating counters with a 1-cycle lookup, write-first
// update forwarding, and a one-entry-per-cycle flush sweep.
module saturating_counter_table
  import saturating_counter_table_pkg::*;
#(
  parameter int ENTRIES     = 16,
  parameter int INDEX_WIDTH = $clog2(ENTRIES),
  parameter int RANGE       = 4,
  parameter int RANGE_LOG2  = $clog2(RANGE),
  parameter int RESET_VALUE = 1,
  parameter int COERCIVITY  = 1
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   lookup_valid,
  input  logic [INDEX_WIDTH-1:0] lookup_index,
  output logic                   lookup_ready,
  output logic                   prediction_valid,
  output logic                   prediction_taken,
  output logic [RANGE_LOG2-1:0]  prediction_count,
  input  logic                   update_valid,
  input  logic [INDEX_WIDTH-1:0] update_index,
  input  logic                   update_taken,
  input  logic                   flush,
  output logic                   busy
);

  // Handshake: a lookup is accepted on a rising edge where lookup_valid and
  // lookup_ready are both high; its result appears with prediction_valid on the
  // following cycle. Updates have no handshake and are simply dropped while busy.

  localparam logic [RANGE_LOG2-1:0]  RESET_COUNT = RANGE_LOG2'(RESET_VALUE);
  localparam logic [RANGE_LOG2-1:0]  HALF_HIGH   = RANGE_LOG2'(counter_half_high(RANGE));
  localparam logic [INDEX_WIDTH-1:0] LAST_INDEX  = INDEX_WIDTH'(ENTRIES - 1);

  sct_state_e             state_q, state_d;
  logic [INDEX_WIDTH-1:0] ptr_q, ptr_d;
  logic [RANGE_LOG2-1:0]  table_q [ENTRIES];
  logic [RANGE_LOG2-1:0]  table_d [ENTRIES];
  logic                   pred_valid_q, pred_valid_d;
  logic [RANGE_LOG2-1:0]  pred_count_q, pred_count_d;

  logic                   update_en;
  logic                   lookup_en;
  logic [RANGE_LOG2-1:0]  update_cur;
  logic [RANGE_LOG2-1:0]  update_next;

  assign busy         = (state_q == ST_FLUSH);
  assign lookup_ready = (state_q != ST_FLUSH);
  assign lookup_en    = lookup_valid && lookup_ready;
  // A flush request in the same cycle wins over a training update.
  assign update_en    = update_valid && (state_q == ST_IDLE) && !flush;
  assign update_cur   = table_q[update_index];

  hysteresis_counter_step #(
    .RANGE      (RANGE),
    .RANGE_LOG2 (RANGE_LOG2),
    .COERCIVITY (COERCIVITY)
  ) u_step (
    .count      (update_cur),
    .increment  (update_en && update_taken),
    .decrement  (update_en && !update_taken),
    .next_count (update_next)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    table_d = table_q;
    case (state_q)
      ST_IDLE: begin
        if (flush) begin
          state_d = ST_FLUSH;
          ptr_d   = '0;
        end else if (update_en) begin
          table_d[update_index] = update_next;
        end
      end
      ST_FLUSH: begin
        table_d[ptr_q] = RESET_COUNT;
        ptr_d          = ptr_q + 1'b1;
        if (ptr_q == LAST_INDEX) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  // Same-index update forwards its post-update value to the lookup.
  always_comb begin
    pred_valid_d = lookup_en;
    pred_count_d = pred_count_q;
    if (lookup_en) begin
      if (update_en && (update_index == lookup_index)) pred_count_d = update_next;
      else                                             pred_count_d = table_q[lookup_index];
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      pred_valid_q <= 1'b0;
      pred_count_q <= RESET_COUNT;
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= RESET_COUNT;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      pred_valid_q <= pred_valid_d;
      pred_count_q <= pred_count_d;
      table_q      <= table_d;
    end
  end

  assign prediction_valid = pred_valid_q;
  assign prediction_count = pred_count_q;
  assign prediction_taken = (pred_count_q >= HALF_HIGH);

endmodule

// File: tb/tb_saturating_counter_table.sv
// Directed bench for saturating_counter_table (16 entries, 4 states, reset value 1,
// coercivity 1); expected counter values are hand-derived from the hysteresis rules.
module tb_saturating_counter_table;

  logic       clock;
  logic       resetn;
  logic       lookup_valid;
  logic [3:0] lookup_index;
  logic       lookup_ready;
  logic       prediction_valid;
  logic       prediction_taken;
  logic [1:0] prediction_count;
  logic       update_valid;
  logic [3:0] update_index;
  logic       update_taken;
  logic       flush;
  logic       busy;

  int total = 0;
  int bad   = 0;
  logic [1:0] exp_q[$];

  saturating_counter_table dut (
    .clock            (clock),
    .resetn           (resetn),
    .lookup_valid     (lookup_valid),
    .lookup_index     (lookup_index),
    .lookup_ready     (lookup_ready),
    .prediction_valid (prediction_valid),
    .prediction_taken (prediction_taken),
    .prediction_count (prediction_count),
    .update_valid     (update_valid),
    .update_index     (update_index),
    .update_taken     (update_taken),
    .flush            (flush),
    .busy             (busy)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_update(input logic [3:0] idx, input logic taken);
    update_valid = 1'b1;
    update_index = idx;
    update_taken = taken;
    tick();
    update_valid = 1'b0;
  endtask

  task automatic do_lookup(input string tag, input logic [3:0] idx, input logic [1:0] exp);
    lookup_valid = 1'b1;
    lookup_index = idx;
    exp_q.push_back(exp);
    tick();
    lookup_valid = 1'b0;
    check({tag, "_valid"}, 32'(prediction_valid), 32'd1);
    if (exp_q.size() != 0) begin
      logic [1:0] e;
      e = exp_q.pop_front();
      check({tag, "_count"}, 32'(prediction_count), 32'(e));
      check({tag, "_taken"}, 32'(prediction_taken), 32'(e >= 2'd2));
    end
  endtask

  initial begin
    int n;
    resetn       = 1'b0;
    lookup_valid = 1'b0;
    lookup_index = '0;
    update_valid = 1'b0;
    update_index = '0;
    update_taken = 1'b0;
    flush        = 1'b0;
    repeat (3) tick();
    check("rst_busy",   32'(busy),             32'd0);
    check("rst_ready",  32'(lookup_ready),     32'd1);
    check("rst_pvalid", 32'(prediction_valid), 32'd0);
    check("rst_count",  32'(prediction_count), 32'd1);
    check("rst_taken",  32'(prediction_taken), 32'd0);
    resetn = 1'b1;
    tick();

    // Plain lookup, then an idle cycle holds the data and drops valid.
    do_lookup("lk5", 4'd5, 2'd1);
    tick();
    check("hold_pvalid", 32'(prediction_valid), 32'd0);
    check("hold_count",  32'(prediction_count), 32'd1);

    // Hysteresis walk on entry 3: 1 -> 3 -> 2 -> 0 -> 0.
    do_update(4'd3, 1'b1);
    do_lookup("e3_inc", 4'd3, 2'd3);
    do_update(4'd3, 1'b0);
    do_lookup("e3_dec1", 4'd3, 2'd2);
    do_update(4'd3, 1'b0);
    do_lookup("e3_dec2", 4'd3, 2'd0);
    do_update(4'd3, 1'b0);
    do_lookup("e3_sat0", 4'd3, 2'd0);
    do_update(4'd3, 1'b1);
    do_update(4'd3, 1'b1);
    do_update(4'd3, 1'b1);
    do_lookup("e3_sat3", 4'd3, 2'd3);
    do_update(4'd3, 1'b0);
    do_update(4'd3, 1'b0);
    do_update(4'd3, 1'b0);
    do_lookup("e3_back0", 4'd3, 2'd0);
    do_lookup("e4_untouched", 4'd4, 2'd1);

    // Back-to-back updates on entry 6: inc (1->3) then dec (3->2).
    update_valid = 1'b1;
    update_index = 4'd6;
    update_taken = 1'b1;
    tick();
    update_taken = 1'b0;
    tick();
    update_valid = 1'b0;
    do_lookup("e6_b2b", 4'd6, 2'd2);

    // Same-cycle update + lookup of entry 7 returns the post-update value.
    update_valid = 1'b1;
    update_index = 4'd7;
    update_taken = 1'b1;
    do_lookup("fwd_e7_inc", 4'd7, 2'd3);
    update_taken = 1'b0;
    update_valid = 1'b1;
    do_lookup("fwd_e7_dec", 4'd7, 2'd2);
    update_valid = 1'b0;

    // Different indices in the same cycle stay independent.
    update_valid = 1'b1;
    update_index = 4'd8;
    update_taken = 1'b1;
    do_lookup("indep_e9", 4'd9, 2'd1);
    update_valid = 1'b0;
    do_lookup("indep_e8", 4'd8, 2'd3);

    // Flush sweep: entries 0 and 15 trained to 3; update in the flush cycle is dropped.
    do_update(4'd0, 1'b1);
    do_update(4'd15, 1'b1);
    flush        = 1'b1;
    update_valid = 1'b1;
    update_index = 4'd1;
    update_taken = 1'b1;
    tick();
    flush        = 1'b0;
    check("flush_busy",  32'(busy),         32'd1);
    check("flush_ready", 32'(lookup_ready), 32'd0);
    update_index = 4'd2;
    lookup_valid = 1'b1;
    lookup_index = 4'd2;
    flush        = 1'b1;
    n = 0;
    while (busy && n < 40) begin
      n++;
      tick();
      flush = 1'b0;
      if (n == 3) check("flush_no_pred", 32'(prediction_valid), 32'd0);
    end
    update_valid = 1'b0;
    lookup_valid = 1'b0;
    check("flush_cycles", 32'(n), 32'd16);
    check("post_flush_busy", 32'(busy), 32'd0);
    do_lookup("flushed_e0",  4'd0,  2'd1);
    do_lookup("flushed_e15", 4'd15, 2'd1);
    do_lookup("dropped_e1",  4'd1,  2'd1);
    do_lookup("ignored_e2",  4'd2,  2'd1);
    do_lookup("flushed_e8",  4'd8,  2'd1);

    // Reset in the middle of a sweep aborts it.
    do_update(4'd5, 1'b1);
    do_lookup("pre_abort_e5", 4'd5, 2'd3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (7) tick();
    check("mid_sweep_busy", 32'(busy), 32'd1);
    resetn = 1'b0;
    #1;
    check("abort_busy",   32'(busy),             32'd0);
    check("abort_ready",  32'(lookup_ready),     32'd1);
    check("abort_pvalid", 32'(prediction_valid), 32'd0);
    check("abort_count",  32'(prediction_count), 32'd1);
    check("abort_taken",  32'(prediction_taken), 32'd0);
    tick();
    resetn = 1'b1;
    tick();
    check("after_abort_busy", 32'(busy), 32'd0);
    do_lookup("abort_e5",  4'd5,  2'd1);
    do_lookup("abort_e15", 4'd15, 2'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
